// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS step sequencer.
package mc_cpu_pkg;

    // Sequencer states; the numeric encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    // PC source select.
    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_J   = 2'd2;

    // Bit positions inside the decoder stage code.
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 0;

endpackage

// File: rtl/mc_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module mc_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count up on inc, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/mc_stage_sequencer.sv
// Multi-cycle MIPS step sequencer: walks IF/ID/EX/MEM/WB according to the
// decoder's stage mask, issues one-hot step enables and selects the PC source.
module mc_stage_sequencer
    import mc_cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       stage_code,
    input  logic             halt,
    input  logic             jump,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             id_en,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             retire,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t     cur_st;
    state_t     nxt_st;
    logic [2:0] code_q;
    logic       halt_q;
    logic       jump_q;
    logic       branch_q;
    logic       active;

    assign state  = cur_st;
    assign active = (cur_st != ST_RST) && (cur_st != ST_HALT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st <= ST_RST;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Capture the decoder's answer on the edge that leaves ID; the decoder
    // outputs are only meaningful while id_en is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= '0;
            halt_q   <= 1'b0;
            jump_q   <= 1'b0;
            branch_q <= 1'b0;
        end else if (cur_st == ST_ID) begin
            code_q   <= stage_code;
            halt_q   <= halt;
            jump_q   <= jump;
            branch_q <= branch;
        end
    end

    // halted follows HALT by one cycle so it is glitch-free for the outside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else begin
            halted <= (cur_st == ST_HALT) && halt_q;
        end
    end

    // Next-state and step-enable decode.
    always_comb begin
        nxt_st  = cur_st;
        id_en   = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = PC_SEL_SEQ;
        ex_en   = 1'b0;
        mem_en  = 1'b0;
        wb_en   = 1'b0;
        retire  = 1'b0;
        illegal = 1'b0;
        case (cur_st)
            ST_RST: begin
                nxt_st = ST_IF;
            end
            ST_IF: begin
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = PC_SEL_SEQ;
                    nxt_st = ST_ID;
                end
            end
            ST_ID: begin
                id_en = 1'b1;
                if (halt) begin
                    retire = 1'b1;
                    nxt_st = ST_HALT;
                end else if (jump) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_SEL_J;
                    retire = 1'b1;
                    nxt_st = ST_IF;
                end else if (stage_code == 3'b000) begin
                    retire = 1'b1;
                    nxt_st = ST_IF;
                end else if (!stage_code[STG_EX]) begin
                    // Work without an EX step is not a real instruction class.
                    illegal = 1'b1;
                    nxt_st  = ST_IF;
                end else begin
                    nxt_st = ST_EX;
                end
            end
            ST_EX: begin
                ex_en = code_q[STG_EX];
                // A latched jump never reaches EX; the gate keeps a stray
                // branch flag from ever redirecting a jump.
                if (branch_q && !jump_q && branch_taken) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_SEL_BR;
                end
                if (code_q[STG_MEM]) begin
                    nxt_st = ST_MEM;
                end else if (code_q[STG_WB]) begin
                    nxt_st = ST_WB;
                end else begin
                    retire = 1'b1;
                    nxt_st = ST_IF;
                end
            end
            ST_MEM: begin
                mem_en = 1'b1;
                if (dmem_ready) begin
                    if (code_q[STG_WB]) begin
                        nxt_st = ST_WB;
                    end else begin
                        retire = 1'b1;
                        nxt_st = ST_IF;
                    end
                end
            end
            ST_WB: begin
                wb_en  = 1'b1;
                retire = 1'b1;
                nxt_st = ST_IF;
            end
            ST_HALT: begin
                nxt_st = ST_HALT;
            end
            default: begin
                nxt_st = ST_RST;
            end
        endcase
    end

    mc_sat_counter #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .cnt   (inst_cnt)
    );

    mc_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (active),
        .cnt   (cycle_cnt)
    );

endmodule

// File: tb/tb_mc_stage_sequencer.sv
// Directed bench for mc_stage_sequencer: one short program per instruction class.
module tb_mc_stage_sequencer;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    // Control vector: {id_en, ir_we, pc_we, pc_sel[1:0], ex_en, mem_en, wb_en, retire, illegal}
    localparam logic [9:0] C_NONE   = 10'b0000000000;
    localparam logic [9:0] C_IF     = 10'b0110000000;
    localparam logic [9:0] C_ID     = 10'b1000000000;
    localparam logic [9:0] C_ID_J   = 10'b1011000010;
    localparam logic [9:0] C_ID_RET = 10'b1000000010;
    localparam logic [9:0] C_ID_ILL = 10'b1000000001;
    localparam logic [9:0] C_EX     = 10'b0000010000;
    localparam logic [9:0] C_EX_BT  = 10'b0010110010;
    localparam logic [9:0] C_EX_RET = 10'b0000010010;
    localparam logic [9:0] C_MEM    = 10'b0000001000;
    localparam logic [9:0] C_WB     = 10'b0000000110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  stage_code = 3'b000;
    logic        halt = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        id_en, ir_we, pc_we, ex_en, mem_en, wb_en, retire, halted, illegal;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic [31:0] inst_cnt, cycle_cnt;
    logic [9:0]  ctl_vec;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ctl_vec = {id_en, ir_we, pc_we, pc_sel, ex_en, mem_en, wb_en, retire, illegal};

    mc_stage_sequencer #(.CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stage_code   (stage_code),
        .halt         (halt),
        .jump         (jump),
        .branch       (branch),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .id_en        (id_en),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .ex_en        (ex_en),
        .mem_en       (mem_en),
        .wb_en        (wb_en),
        .retire       (retire),
        .halted       (halted),
        .illegal      (illegal),
        .state        (state),
        .inst_cnt     (inst_cnt),
        .cycle_cnt    (cycle_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Check state and control vector for the current cycle, then advance one cycle.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [9:0] ec);
        #1;
        check({tag, " state"}, 32'(state), 32'(es));
        check({tag, " ctl"}, 32'(ctl_vec), 32'(ec));
        tick();
    endtask

    // Reset, release, and stop at the first IF cycle.
    task automatic do_reset();
        rst_n        = 1'b0;
        stage_code   = 3'b000;
        halt         = 1'b0;
        jump         = 1'b0;
        branch       = 1'b0;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst state", 32'(state), 32'(S_RST));
        check("rst ctl", 32'(ctl_vec), 32'(C_NONE));
        check("rst inst_cnt", inst_cnt, 32'd0);
        check("rst cycle_cnt", cycle_cnt, 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst idle state", 32'(state), 32'(S_RST));
        tick();

        // R-type, with a stray branch_taken that must not redirect
        imem_ready   = 1'b1;
        stage_code   = 3'b101;
        branch_taken = 1'b1;
        cyc("r if", S_IF, C_IF);
        cyc("r id", S_ID, C_ID);
        cyc("r ex", S_EX, C_EX);
        cyc("r wb", S_WB, C_WB);
        #1;
        check("r next state", 32'(state), 32'(S_IF));
        check("r inst_cnt", inst_cnt, 32'd1);
        check("r cycle_cnt", cycle_cnt, 32'd4);
        tick();

        // lw with three data-memory wait cycles; early dmem_ready is ignored
        do_reset();
        imem_ready = 1'b1;
        stage_code = 3'b111;
        dmem_ready = 1'b1;
        cyc("lw if", S_IF, C_IF);
        cyc("lw id", S_ID, C_ID);
        cyc("lw ex", S_EX, C_EX);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw mem wait", S_MEM, C_MEM);
        dmem_ready = 1'b1;
        cyc("lw mem done", S_MEM, C_MEM);
        cyc("lw wb", S_WB, C_WB);
        #1;
        check("lw next state", 32'(state), 32'(S_IF));
        check("lw inst_cnt", inst_cnt, 32'd1);
        check("lw cycle_cnt", cycle_cnt, 32'd8);
        tick();

        // beq taken
        do_reset();
        imem_ready   = 1'b1;
        stage_code   = 3'b100;
        branch       = 1'b1;
        branch_taken = 1'b1;
        cyc("bt if", S_IF, C_IF);
        cyc("bt id", S_ID, C_ID);
        cyc("bt ex", S_EX, C_EX_BT);
        #1;
        check("bt next state", 32'(state), 32'(S_IF));
        check("bt inst_cnt", inst_cnt, 32'd1);
        tick();

        // beq not taken
        do_reset();
        imem_ready = 1'b1;
        stage_code = 3'b100;
        branch     = 1'b1;
        cyc("bn if", S_IF, C_IF);
        cyc("bn id", S_ID, C_ID);
        cyc("bn ex", S_EX, C_EX_RET);
        #1;
        check("bn next state", 32'(state), 32'(S_IF));
        tick();

        // jump
        do_reset();
        imem_ready = 1'b1;
        jump       = 1'b1;
        cyc("j if", S_IF, C_IF);
        cyc("j id", S_ID, C_ID_J);
        #1;
        check("j next state", 32'(state), 32'(S_IF));
        check("j inst_cnt", inst_cnt, 32'd1);
        check("j cycle_cnt", cycle_cnt, 32'd2);
        tick();

        // halt: absorbing, counters frozen, reset leaves
        do_reset();
        imem_ready = 1'b1;
        halt       = 1'b1;
        cyc("h if", S_IF, C_IF);
        cyc("h id", S_ID, C_ID_RET);
        #1;
        check("h state", 32'(state), 32'(S_HALT));
        check("h ctl", 32'(ctl_vec), 32'(C_NONE));
        check("h halted first", 32'(halted), 32'd0);
        tick();
        check("h halted next", 32'(halted), 32'd1);
        repeat (20) tick();
        check("h state held", 32'(state), 32'(S_HALT));
        check("h cycle_cnt frozen", cycle_cnt, 32'd2);
        check("h inst_cnt", inst_cnt, 32'd1);
        rst_n = 1'b0;
        #1;
        check("h rst state", 32'(state), 32'(S_RST));
        check("h rst inst_cnt", inst_cnt, 32'd0);
        check("h rst cycle_cnt", cycle_cnt, 32'd0);
        check("h rst halted", 32'(halted), 32'd0);
        tick();

        // illegal stage code 011
        do_reset();
        imem_ready = 1'b1;
        stage_code = 3'b011;
        cyc("il if", S_IF, C_IF);
        cyc("il id", S_ID, C_ID_ILL);
        #1;
        check("il inst_cnt", inst_cnt, 32'd0);
        cyc("il next if", S_IF, C_IF);

        // reset asserted mid-MEM
        do_reset();
        imem_ready = 1'b1;
        stage_code = 3'b111;
        cyc("rm if", S_IF, C_IF);
        cyc("rm id", S_ID, C_ID);
        cyc("rm ex", S_EX, C_EX);
        cyc("rm mem", S_MEM, C_MEM);
        rst_n = 1'b0;
        #1;
        check("rm state", 32'(state), 32'(S_RST));
        check("rm ctl", 32'(ctl_vec), 32'(C_NONE));
        check("rm inst_cnt", inst_cnt, 32'd0);
        check("rm cycle_cnt", cycle_cnt, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
